// File: rtl/firebird7_in_gate1_mux_ctrl_pkg.sv
// Shared types and defaults for the gate1 IJTAG/functional data mux sequencer.
package firebird7_in_gate1_mux_ctrl_pkg;

  localparam int DATA_WIDTH_DEFAULT    = 19;
  localparam int SETTLE_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    CAPTURE   = 3'd2,
    SETTLE_ON = 3'd3,
    ACTIVE    = 3'd4,
    RELEASE   = 3'd5
  } state_e;

  // Counter width able to hold n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_mux_settle_cnt.sv
// Saturating up-counter: clear has priority, stops at TERM and flags it on tc.
module firebird7_in_gate1_mux_settle_cnt #(
  parameter int CNT_W = 3,
  parameter int TERM  = 3
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt >= TERM_V);

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset)   cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Glitch-safe handover sequencer for the gate1 IJTAG/functional data mux.
// Optional WAIT_IDLE timeout: define FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN.
module firebird7_in_gate1_tessent_data_mux_ctrl
  import firebird7_in_gate1_mux_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_override_req,
  input  logic                  ijtag_load_en,
  input  logic [DATA_WIDTH-1:0] ijtag_data_reg,
  input  logic [DATA_WIDTH-1:0] functional_data_in,
  input  logic                  func_idle,
  output logic                  mux_select,
  output logic [DATA_WIDTH-1:0] mux_ijtag_data,
  output logic                  override_active,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] capture_data
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
  , output logic                timeout_flag
`endif
);

  localparam int CNT_W       = cnt_width(SETTLE_CYCLES);
  localparam int SETTLE_TERM = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  state_e                  state_q, state_d;
  logic                    settle_en, settle_tc, settle_done;
  logic                    wait_expired;
  logic                    sel_d, busy_d;
  logic [DATA_WIDTH-1:0]   data_d, cap_d;

  // One counter serves both SETTLE_ON and RELEASE; it is cleared in every other state.
  assign settle_en   = (state_q == SETTLE_ON) || (state_q == RELEASE);
  assign settle_done = (SETTLE_CYCLES == 0) || settle_tc;

  firebird7_in_gate1_mux_settle_cnt #(
    .CNT_W (CNT_W),
    .TERM  (SETTLE_TERM)
  ) u_settle_cnt (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .clr         (!settle_en),
    .en          (settle_en),
    .tc          (settle_tc)
  );

`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
  localparam int TO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam int TO_TERM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic wait_en;
  logic flag_d;

  assign wait_en = (state_q == WAIT_IDLE);

  firebird7_in_gate1_mux_settle_cnt #(
    .CNT_W (TO_W),
    .TERM  (TO_TERM)
  ) u_timeout_cnt (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .clr         (!wait_en),
    .en          (wait_en),
    .tc          (wait_expired)
  );
`else
  assign wait_expired = 1'b0;
`endif

  // State and registered outputs; reset drops the select without waiting for a clock.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q         <= IDLE;
      mux_select      <= 1'b0;
      override_active <= 1'b0;
      busy            <= 1'b0;
      mux_ijtag_data  <= '0;
      capture_data    <= '0;
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
      timeout_flag    <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      mux_select      <= sel_d;
      override_active <= sel_d;
      busy            <= busy_d;
      mux_ijtag_data  <= data_d;
      capture_data    <= cap_d;
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
      timeout_flag    <= flag_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (ijtag_override_req) state_d = WAIT_IDLE;
      WAIT_IDLE: begin
        if (!ijtag_override_req)            state_d = IDLE;
        else if (func_idle || wait_expired) state_d = CAPTURE;
      end
      CAPTURE:   state_d = (SETTLE_CYCLES == 0) ? ACTIVE : SETTLE_ON;
      // An abort wins over completion so the select can never pulse.
      SETTLE_ON: begin
        if (!ijtag_override_req) state_d = IDLE;
        else if (settle_done)    state_d = ACTIVE;
      end
      ACTIVE:    if (!ijtag_override_req) state_d = RELEASE;
      RELEASE:   if (settle_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = mux_ijtag_data;
    cap_d  = capture_data;
    case (state_q)
      IDLE, WAIT_IDLE, RELEASE: data_d = functional_data_in;
      CAPTURE: begin
        data_d = functional_data_in;
        cap_d  = functional_data_in;
      end
      SETTLE_ON: data_d = capture_data;
      ACTIVE:    data_d = ijtag_load_en ? ijtag_data_reg : capture_data;
      default:   data_d = '0;
    endcase
    sel_d  = (state_d == ACTIVE) || (state_d == RELEASE);
    busy_d = !((state_d == IDLE) || (state_d == ACTIVE));
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
    // Sticky until the next request leaves IDLE; set only when func_idle never came.
    flag_d = timeout_flag;
    if ((state_q == IDLE) && (state_d == WAIT_IDLE))
      flag_d = 1'b0;
    else if ((state_q == WAIT_IDLE) && (state_d == CAPTURE) && !func_idle)
      flag_d = 1'b1;
`endif
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Self-checking bench: vector table, hand-written corner sequences, random run vs reference model.
`timescale 1ns/1ps
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  localparam int DW = 19;
  localparam int S  = 4;
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
  localparam int TO = 64;
`endif

  logic          ijtag_tck   = 1'b0;
  logic          ijtag_reset = 1'b0;
  logic          req = 1'b0, ld = 1'b0, fidle = 1'b0;
  logic [DW-1:0] dreg = '0, fdi = '0;
  logic          sel, ovr, busy;
  logic [DW-1:0] mdata, cap;
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
  logic          tflag;
`endif

  int errors = 0;
  int checks = 0;

  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate1_tessent_data_mux_ctrl #(
    .DATA_WIDTH    (DW),
    .SETTLE_CYCLES (S)
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_override_req (req),
    .ijtag_load_en      (ld),
    .ijtag_data_reg     (dreg),
    .functional_data_in (fdi),
    .func_idle          (fidle),
    .mux_select         (sel),
    .mux_ijtag_data     (mdata),
    .override_active    (ovr),
    .busy               (busy),
    .capture_data       (cap)
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
    , .timeout_flag     (tflag)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ijtag_tck);
    #1;
  endtask

  // Reference model: phase plus remaining-cycle countdown, advanced once per edge.
  localparam int P_IDLE = 0, P_WAIT = 1, P_CAP = 2, P_SET = 3, P_ACT = 4, P_REL = 5;
  int            m_ph, m_left, m_wait;
  logic [DW-1:0] m_data, m_cap;
  logic          m_flag;

  task automatic model_reset();
    m_ph = P_IDLE; m_left = 0; m_wait = 0;
    m_data = '0; m_cap = '0; m_flag = 1'b0;
  endtask

  task automatic model_step();
    case (m_ph)
      P_IDLE: begin
        m_data = fdi;
        if (req) begin m_ph = P_WAIT; m_wait = 0; m_flag = 1'b0; end
      end
      P_WAIT: begin
        m_data = fdi;
        m_wait++;
        if (!req) m_ph = P_IDLE;
        else if (fidle) m_ph = P_CAP;
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
        else if (m_wait >= TO) begin m_ph = P_CAP; m_flag = 1'b1; end
`endif
      end
      P_CAP: begin
        m_data = fdi;
        m_cap  = fdi;
        if (S == 0) m_ph = P_ACT;
        else begin m_ph = P_SET; m_left = S; end
      end
      P_SET: begin
        m_data = m_cap;
        if (!req) m_ph = P_IDLE;
        else begin
          m_left--;
          if (m_left == 0) m_ph = P_ACT;
        end
      end
      P_ACT: begin
        m_data = ld ? dreg : m_cap;
        if (!req) begin m_ph = P_REL; m_left = (S == 0) ? 1 : S; end
      end
      default: begin
        m_data = fdi;
        m_left--;
        if (m_left <= 0) m_ph = P_IDLE;
      end
    endcase
  endtask

  typedef struct {
    logic          req;
    logic          fi;
    logic          ld;
    logic [DW-1:0] dreg;
    logic [DW-1:0] fdi;
    logic          e_sel;
    logic          e_busy;
    logic [DW-1:0] e_data;
    logic [DW-1:0] e_cap;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // req in, func_idle at capture then dropped, load override, release with changing functional data
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 19'h00000, 19'h2A5C3, 1'b0, 1'b1, 19'h2A5C3, 19'h00000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 19'h00000, 19'h2A5C3, 1'b0, 1'b1, 19'h2A5C3, 19'h00000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 19'h00000, 19'h2A5C3, 1'b0, 1'b1, 19'h2A5C3, 19'h2A5C3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 19'h11111, 1'b0, 1'b1, 19'h2A5C3, 19'h2A5C3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 19'h22222, 1'b0, 1'b1, 19'h2A5C3, 19'h2A5C3};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 19'h33333, 1'b0, 1'b1, 19'h2A5C3, 19'h2A5C3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 19'h44444, 1'b1, 1'b0, 19'h2A5C3, 19'h2A5C3};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 19'h7FFFF, 19'h44444, 1'b1, 1'b0, 19'h7FFFF, 19'h2A5C3};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 19'h7FFFF, 19'h44444, 1'b1, 1'b0, 19'h2A5C3, 19'h2A5C3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 19'h00000, 19'h12345, 1'b1, 1'b1, 19'h2A5C3, 19'h2A5C3};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 19'h00000, 19'h0ABCD, 1'b1, 1'b1, 19'h0ABCD, 19'h2A5C3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 19'h00000, 19'h1F0F0, 1'b1, 1'b1, 19'h1F0F0, 19'h2A5C3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 19'h00000, 19'h00F0F, 1'b1, 1'b1, 19'h00F0F, 19'h2A5C3};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 19'h00000, 19'h55555, 1'b0, 1'b0, 19'h55555, 19'h2A5C3};

    // Reset held with the request and func_idle already high
    req = 1'b1; fidle = 1'b1; fdi = 19'h2A5C3;
    repeat (3) tick();
    chk1("rst_sel", sel, 1'b0);
    chk1("rst_ovr", ovr, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkd("rst_data", mdata, '0);
    chkd("rst_cap", cap, '0);
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
    chk1("rst_tflag", tflag, 1'b0);
`endif
    ijtag_reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      req = vecs[i].req; fidle = vecs[i].fi; ld = vecs[i].ld;
      dreg = vecs[i].dreg; fdi = vecs[i].fdi;
      tick();
      chk1($sformatf("vec%0d_sel", i), sel, vecs[i].e_sel);
      chk1($sformatf("vec%0d_ovr", i), ovr, vecs[i].e_sel);
      chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chkd($sformatf("vec%0d_data", i), mdata, vecs[i].e_data);
      chkd($sformatf("vec%0d_cap", i), cap, vecs[i].e_cap);
    end

    // Abort on the second SETTLE_ON cycle: select must never pulse
    req = 1'b1; fidle = 1'b1; fdi = 19'h3C3C3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("abort_sel", sel, 1'b0);
      chk1("abort_busy", busy, 1'b1);
    end
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("abort_sel_after", sel, 1'b0);
      chk1("abort_ovr_after", ovr, 1'b0);
      chk1("abort_busy_after", busy, 1'b0);
    end
    chkd("abort_cap", cap, 19'h3C3C3);

    // func_idle held low with the request up
    req = 1'b1; fidle = 1'b0; fdi = 19'h01234;
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      tick();
      chk1("to_wait_sel", sel, 1'b0);
      chk1("to_wait_flag", tflag, 1'b0);
    end
    tick();
    chk1("to_flag_set", tflag, 1'b1);
    chk1("to_busy", busy, 1'b1);
    repeat (S + 1) tick();
    chk1("to_sel_on", sel, 1'b1);
    chkd("to_cap", cap, 19'h01234);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk1("wait_sel", sel, 1'b0);
      chk1("wait_busy", busy, 1'b1);
    end
    fidle = 1'b1;
    repeat (S + 1) tick();
    chk1("wait_sel_pre", sel, 1'b0);
    tick();
    chk1("wait_sel_on", sel, 1'b1);
    chkd("wait_cap", cap, 19'h01234);
`endif
    req = 1'b0;
    repeat (S) tick();
    chk1("wait_rel_sel_hold", sel, 1'b1);
    tick();
    chk1("wait_rel_sel_off", sel, 1'b0);
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
    chk1("to_flag_sticky", tflag, 1'b1);
    req = 1'b1; fidle = 1'b1;
    tick();
    chk1("to_flag_clear", tflag, 1'b0);
    req = 1'b0;
    tick();
`endif

    // Asynchronous reset between edges while ACTIVE
    req = 1'b1; fidle = 1'b1; fdi = 19'h6ACE1;
    repeat (3 + S) tick();
    chk1("arst_pre_sel", sel, 1'b1);
    #2;
    ijtag_reset = 1'b0;
    #1;
    chk1("arst_sel", sel, 1'b0);
    chk1("arst_ovr", ovr, 1'b0);
    chkd("arst_cap", cap, '0);
    req = 1'b0;
    @(posedge ijtag_tck);
    #1;
    ijtag_reset = 1'b1;
    tick();
    chk1("arst_idle_sel", sel, 1'b0);
    chk1("arst_idle_busy", busy, 1'b0);
    chkd("arst_idle_data", mdata, 19'h6ACE1);
    req = 1'b1;
    tick();
    chk1("arst_restart_busy", busy, 1'b1);

    // Randomized run against the reference model
    req = 1'b0;
    ijtag_reset = 1'b0;
    #1;
    model_reset();
    @(posedge ijtag_tck);
    #1;
    ijtag_reset = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) req = !req;
      fidle = ($urandom_range(0, 2) != 0);
      ld    = ($urandom_range(0, 1) == 1);
      dreg  = DW'($urandom);
      fdi   = DW'($urandom);
      tick();
      model_step();
      chk1("rnd_sel", sel, (m_ph == P_ACT) || (m_ph == P_REL));
      chk1("rnd_ovr", ovr, (m_ph == P_ACT) || (m_ph == P_REL));
      chk1("rnd_busy", busy, !((m_ph == P_IDLE) || (m_ph == P_ACT)));
      chkd("rnd_data", mdata, m_data);
      chkd("rnd_cap", cap, m_cap);
`ifdef FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN
      chk1("rnd_tflag", tflag, m_flag);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl.md
Name: firebird7_in_gate1_tessent_data_mux_ctrl

Overview:
Sequencer for the 19-bit IJTAG/functional data mux in the gate1 IJTAG instrument. It converts a level override request from a TDR bit into a glitch-safe handover. The sequence is: wait for functional idle, capture the live functional value, pre-drive it on the IJTAG leg, settle, then switch. Release runs the same steps in reverse. It drives the mux's select and ijtag_data_in legs directly and returns status and captured data for TDR readback.

Parameters:
- DATA_WIDTH, 19, width of the muxed data path.
- SETTLE_CYCLES, 4, number of ijtag_tck cycles of matched-data settling before the select changes. 0 means no settle state.
- CNT_W, $clog2(SETTLE_CYCLES+1) (minimum 1), settle counter width. Derived; do not override.

Ports:
- ijtag_tck  in  1  sole clock.
- ijtag_reset  in  1  asynchronous, active-low reset.
- ijtag_override_req  in  1  level request from TDR; 1 = take the path over.
- ijtag_load_en  in  1  when 1 in ACTIVE, drive ijtag_data_reg; when 0, hold the captured value.
- ijtag_data_reg  in  DATA_WIDTH  value programmed through the TDR.
- functional_data_in  in  DATA_WIDTH  live functional value (same net as the mux's functional leg).
- func_idle  in  1  functional owner reports the path safe to seize.
- mux_select  out  1  to mux ijtag_select.
- mux_ijtag_data  out  DATA_WIDTH  to mux ijtag_data_in.
- override_active  out  1  1 exactly while mux_select=1.
- busy  out  1  1 in any state other than IDLE and ACTIVE.
- capture_data  out  DATA_WIDTH  shadow register, for TDR readback.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, mux_select=0, mux_ijtag_data=0, capture_data=0, counter=0, override_active=0, busy=0. Reset mid-sequence forces mux_select low immediately, with no clock edge needed.
- All outputs are registered. Transitions occur on the ijtag_tck rising edge.
- IDLE: mux_select=0; mux_ijtag_data follows functional_data_in one cycle late. If req=1, go to WAIT_IDLE.
- WAIT_IDLE: if req=0, go to IDLE. Else if func_idle=1, go to CAPTURE.
- CAPTURE (1 cycle): capture_data <= functional_data_in; mux_ijtag_data <= functional_data_in; counter <= 0. Next state is SETTLE_ON, or ACTIVE if SETTLE_CYCLES=0.
- SETTLE_ON: mux_ijtag_data holds capture_data; counter increments.
  - When counter == SETTLE_CYCLES-1, go to ACTIVE and set mux_select<=1 on that same edge.
  - If req=0, go to IDLE with mux_select never asserted.
- ACTIVE: mux_select=1.
  - mux_ijtag_data <= ijtag_load_en ? ijtag_data_reg : capture_data. This updates every cycle; latency is 1 cycle from input to output.
  - If req=0, go to RELEASE with counter <= 0.
- RELEASE: mux_select stays 1; mux_ijtag_data <= functional_data_in each cycle, so both mux legs match.
  - Counter counts to SETTLE_CYCLES-1, then go to IDLE with mux_select<=0. With SETTLE_CYCLES=0, the select drops on the first RELEASE edge.
- req reasserted during RELEASE: RELEASE completes, then IDLE, then a fresh sequence starts with a new capture. There is no shortcut back to ACTIVE.
- func_idle is ignored outside WAIT_IDLE. A drop of func_idle after CAPTURE does not abort the sequence.
- Counter saturates and never wraps. Minimum latency from req rise to mux_select=1 is 3+SETTLE_CYCLES edges.

Optional Feature:
- Macro: FIREBIRD7_IN_GATE1_MUX_CTRL_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES (default 64) and output timeout_flag (1 bit, reset 0).
  - In WAIT_IDLE, a counter runs. Reaching TIMEOUT_CYCLES without func_idle forces CAPTURE and sets timeout_flag.
  - timeout_flag is sticky until the IDLE->WAIT_IDLE transition of the next request.
- When undefined: WAIT_IDLE waits indefinitely; no extra port or parameter exists.

Decomposition:
- Package firebird7_in_gate1_mux_ctrl_pkg holds:
  - state enum with states IDLE, WAIT_IDLE, CAPTURE, SETTLE_ON, ACTIVE, RELEASE (3-bit, explicit encodings);
  - DATA_WIDTH_DEFAULT=19;
  - SETTLE_CYCLES_DEFAULT=4.
- One sub-module: firebird7_in_gate1_mux_settle_cnt. It is the saturating settle/timeout counter with clear, enable and terminal-count output, instantiated once, or twice when the timeout feature is enabled.

Test Plan:
- Reset with req=1 and func_idle=1 already high -> all outputs 0. After reset release, mux_select rises on the 7th edge (SETTLE_CYCLES=4), with capture_data = the functional_data_in value sampled at CAPTURE (e.g. 19'h2A5C3).
- In ACTIVE, load_en=1 and ijtag_data_reg=19'h7FFFF -> mux_ijtag_data=19'h7FFFF one cycle later. Then load_en=0 -> reverts to capture_data.
- Drop req in ACTIVE -> mux_ijtag_data tracks functional_data_in; mux_select falls exactly 4 edges later; busy=1 throughout RELEASE.
- Drop req on the 2nd SETTLE_ON cycle -> returns to IDLE; mux_select never pulses; override_active stays 0.
- Hold func_idle=0 with req=1 -> remains in WAIT_IDLE indefinitely. With TIMEOUT_EN and TIMEOUT_CYCLES=64 -> CAPTURE after 64 cycles and timeout_flag=1.
- Assert ijtag_reset low mid-ACTIVE, between clock edges -> mux_select=0 immediately; state=IDLE after release.
